// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser SDRAM capture path: writer FSM
// states and the f2h_sdram0 Avalon-MM port widths.
package la_pkg;

    localparam int unsigned SDRAM_DATA_W = 256;
    localparam int unsigned SDRAM_BE_W   = 32;
    localparam int unsigned BURSTCOUNT_W = 8;
    localparam int unsigned LEVEL_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_BURST,
        ST_DONE
    } wr_state_e;

endpackage

// File: rtl/sdram_burst_writer.sv
// Drains the capture FIFO into an SDRAM buffer as Avalon-MM burst writes.
// Define LA_BURST_WRITER_RING_EN to run the buffer as a ring until stop.
module sdram_burst_writer
    import la_pkg::*;
#(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ADDR_W    = 27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       buf_words,
    input  logic [SDRAM_DATA_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LEVEL_W-1:0]      in_level,
    output logic [ADDR_W-1:0]       avm_address,
    output logic [BURSTCOUNT_W-1:0] avm_burstcount,
    output logic                    avm_write,
    output logic [SDRAM_DATA_W-1:0] avm_writedata,
    output logic [SDRAM_BE_W-1:0]   avm_byteenable,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    done,
    output logic                    wrapped,
    output logic [ADDR_W-1:0]       wr_offset
);

    wr_state_e               r_state;
    wr_state_e               w_next;
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W-1:0]       r_buf_words;
    logic [ADDR_W-1:0]       r_wr_offset;
    logic                    r_wrapped;
    logic                    r_stop;
    logic [ADDR_W-1:0]       r_addr;
    logic [BURSTCOUNT_W-1:0] r_bcount;
    logic [BURSTCOUNT_W-1:0] r_beat;

    logic [ADDR_W-1:0]       w_remaining;
    logic [BURSTCOUNT_W-1:0] w_len;
    logic                    w_issue;
    logic [BURSTCOUNT_W-1:0] w_issue_len;
    logic                    w_accept;
    logic                    w_last;
    logic [ADDR_W-1:0]       w_next_off;
    logic                    w_buf_full;
    logic                    w_idle_like;
    logic                    w_busy;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_busy      = (r_state == ST_WAIT_DATA) || (r_state == ST_BURST);

    // Next burst never crosses the end of the buffer.
    assign w_remaining = r_buf_words - r_wr_offset;
    assign w_len       = (w_remaining >= ADDR_W'(BURST_LEN)) ? BURSTCOUNT_W'(BURST_LEN)
                                                             : w_remaining[BURSTCOUNT_W-1:0];

    assign w_accept   = avm_write && !avm_waitrequest;
    assign w_last     = w_accept && (r_beat == r_bcount - 1'b1);
    assign w_next_off = r_wr_offset + {{(ADDR_W-BURSTCOUNT_W){1'b0}}, r_bcount};
    assign w_buf_full = (w_next_off == r_buf_words);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_issue     = 1'b0;
        w_issue_len = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if ({1'b0, w_len} <= in_level) begin
                    w_next      = ST_BURST;
                    w_issue     = 1'b1;
                    w_issue_len = w_len;
                end else if (r_stop) begin
                    if (in_level == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next      = ST_BURST;
                        w_issue     = 1'b1;
                        w_issue_len = in_level[BURSTCOUNT_W-1:0];
                    end
                end
            end
            ST_BURST: begin
                if (w_last) begin
`ifdef LA_BURST_WRITER_RING_EN
                    w_next = ST_WAIT_DATA;
`else
                    w_next = w_buf_full ? ST_DONE : ST_WAIT_DATA;
`endif
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base      <= '0;
            r_buf_words <= '0;
            r_wr_offset <= '0;
            r_wrapped   <= 1'b0;
            r_stop      <= 1'b0;
            r_addr      <= '0;
            r_bcount    <= '0;
            r_beat      <= '0;
        end else begin
            if (w_idle_like && start) begin
                r_base      <= base_addr;
                r_buf_words <= buf_words;
                r_wr_offset <= '0;
                r_wrapped   <= 1'b0;
                r_stop      <= 1'b0;
            end else if (w_busy && stop) begin
                r_stop <= 1'b1;
            end

            if (w_issue) begin
                r_addr   <= r_base + r_wr_offset;
                r_bcount <= w_issue_len;
                r_beat   <= '0;
            end

            if (w_accept) begin
                r_beat <= r_beat + 1'b1;
            end

            if (w_last) begin
`ifdef LA_BURST_WRITER_RING_EN
                if (w_buf_full) begin
                    r_wr_offset <= '0;
                    r_wrapped   <= 1'b1;
                end else begin
                    r_wr_offset <= w_next_off;
                end
`else
                r_wr_offset <= w_next_off;
`endif
            end
        end
    end

    assign avm_write      = (r_state == ST_BURST) && in_valid;
    assign in_ready       = (r_state == ST_BURST) && !avm_waitrequest;
    assign avm_writedata  = in_data;
    assign avm_byteenable = '1;
    assign avm_address    = r_addr;
    assign avm_burstcount = r_bcount;
    assign busy           = w_busy;
    assign done           = (r_state == ST_DONE);
    assign wrapped        = r_wrapped;
    assign wr_offset      = r_wr_offset;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Randomized bench for sdram_burst_writer: a queue-based capture FIFO feeds the
// DUT and every accepted beat is compared against a burst-chopping model.
module tb_sdram_burst_writer;
    import la_pkg::*;

    localparam int unsigned BL = 8;
    localparam int unsigned AW = 27;
`ifdef LA_BURST_WRITER_RING_EN
    localparam bit RING = 1'b1;
`else
    localparam bit RING = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    stop;
    logic [AW-1:0]           base_addr;
    logic [AW-1:0]           buf_words;
    logic [SDRAM_DATA_W-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [LEVEL_W-1:0]      in_level;
    logic [AW-1:0]           avm_address;
    logic [BURSTCOUNT_W-1:0] avm_burstcount;
    logic                    avm_write;
    logic [SDRAM_DATA_W-1:0] avm_writedata;
    logic [SDRAM_BE_W-1:0]   avm_byteenable;
    logic                    avm_waitrequest;
    logic                    busy;
    logic                    done;
    logic                    wrapped;
    logic [AW-1:0]           wr_offset;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [SDRAM_DATA_W-1:0] fifo[$];
    logic [SDRAM_DATA_W-1:0] exp_words[$];
    logic [SDRAM_DATA_W-1:0] got_data[$];
    logic [AW-1:0]           got_addr[$];
    logic [7:0]              got_bc[$];

    int unsigned n_total, pushed, wr_mode, stall_left, stall_seen, beat_in_burst;
    bit fast, stall_done, prev_last, prev_stall;
    logic [AW-1:0]           p_addr;
    logic [7:0]              p_bc;
    logic [SDRAM_DATA_W-1:0] p_data;

    always #5 clk = ~clk;

    sdram_burst_writer #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .base_addr(base_addr), .buf_words(buf_words),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_level(in_level),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .wrapped(wrapped), .wr_offset(wr_offset)
    );

    function automatic logic [SDRAM_DATA_W-1:0] rand_word();
        logic [SDRAM_DATA_W-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive_fifo();
        in_valid = (fifo.size() != 0);
        if (fifo.size() != 0) in_data = fifo[0];
        else in_data = '0;
        in_level = LEVEL_W'(fifo.size());
    endtask

    task automatic push_word();
        logic [SDRAM_DATA_W-1:0] w;
        w = rand_word();
        fifo.push_back(w);
        exp_words.push_back(w);
        pushed++;
    endtask

    task automatic reset_tb();
        fifo.delete(); exp_words.delete();
        got_data.delete(); got_addr.delete(); got_bc.delete();
        pushed = 0; stall_left = 0; stall_seen = 0; beat_in_burst = 0;
        stall_done = 1'b0; prev_last = 1'b0; prev_stall = 1'b0;
        avm_waitrequest = 1'b0;
        drive_fifo();
    endtask

    // One clock: observe bus at negedge, then update FIFO/waitrequest after posedge.
    task automatic cycle();
        bit pop;
        @(negedge clk);
        pop = 1'b0;
        if (prev_last) begin
            checks++;
            if (avm_write !== 1'b0) begin
                errors++; $display("FAIL idle_gap avm_write=%b required 0", avm_write);
            end
        end
        if (prev_stall) begin
            checks++;
            if (avm_write !== 1'b1 || avm_address !== p_addr || avm_burstcount !== p_bc ||
                avm_writedata !== p_data) begin
                errors++;
                $display("FAIL stall_hold write=%b addr=%h bc=%0d required addr=%h bc=%0d",
                         avm_write, avm_address, avm_burstcount, p_addr, p_bc);
            end
        end
        if (avm_write === 1'b1) begin
            checks++;
            if (avm_byteenable !== '1) begin
                errors++; $display("FAIL byteenable got %h required all ones", avm_byteenable);
            end
            checks++;
            if (in_ready !== !avm_waitrequest) begin
                errors++; $display("FAIL in_ready got %b required %b", in_ready, !avm_waitrequest);
            end
        end
        prev_last  = 1'b0;
        prev_stall = (avm_write === 1'b1) && avm_waitrequest;
        if (prev_stall) stall_seen++;
        p_addr = avm_address; p_bc = avm_burstcount; p_data = avm_writedata;
        if (avm_write === 1'b1 && !avm_waitrequest) begin
            got_addr.push_back(avm_address);
            got_bc.push_back(avm_burstcount);
            got_data.push_back(avm_writedata);
            pop = 1'b1;
            beat_in_burst++;
            if (beat_in_burst == int'(avm_burstcount)) begin
                prev_last = 1'b1;
                beat_in_burst = 0;
            end
        end
        @(posedge clk);
        #1;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        if (pushed < n_total && (fast || $urandom_range(0, 3) != 0)) push_word();
        case (wr_mode)
            1: avm_waitrequest = ($urandom_range(0, 3) == 0);
            2: begin
                if (stall_left != 0) begin
                    avm_waitrequest = 1'b1; stall_left--;
                end else if (!stall_done && beat_in_burst == 2) begin
                    avm_waitrequest = 1'b1; stall_left = 4; stall_done = 1'b1;
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
            default: avm_waitrequest = 1'b0;
        endcase
        drive_fifo();
    endtask

    task automatic run_capture(input logic [AW-1:0] base, input int unsigned bw,
                               input int unsigned n, input int unsigned mode,
                               input bit fst, input bit glitch);
        logic [AW-1:0] e_addr[$];
        logic [7:0]    e_bc[$];
        int unsigned off, rem, len, nb, cmp_n;
        bit e_wrap, fin, stop_sent, glitched;
        reset_tb();
        n_total = n; wr_mode = mode; fast = fst;
        if (fst) while (pushed < n_total) push_word();
        drive_fifo();
        base_addr = base; buf_words = AW'(bw); start = 1'b1;
        cycle();
        start = 1'b0;
        base_addr = AW'($urandom);
        buf_words = AW'(BL * $urandom_range(1, 8));
        fin = 1'b0; stop_sent = 1'b0; glitched = 1'b0;
        for (int i = 0; i < 4000 && !fin; i++) begin
            if (glitch && !glitched && avm_write) begin
                start = 1'b1; base_addr = AW'($urandom); glitched = 1'b1;
            end
            if (!stop_sent && pushed == n_total) begin
                stop = 1'b1; stop_sent = 1'b1;
            end
            cycle();
            start = 1'b0; stop = 1'b0;
            if (done === 1'b1) fin = 1'b1;
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL timeout done=%b required 1", done);
        end

        off = 0; rem = n; e_wrap = 1'b0;
        while (rem > 0) begin
            len = (bw - off < BL) ? bw - off : BL;
            nb  = (rem >= len) ? len : rem;
            for (int k = 0; k < int'(nb); k++) begin
                e_addr.push_back(base + AW'(off));
                e_bc.push_back(8'(nb));
            end
            rem -= nb; off += nb;
            if (off == bw) begin
                if (RING) begin
                    off = 0; e_wrap = 1'b1;
                end else begin
                    break;
                end
            end
        end

        checks++;
        if (got_addr.size() != e_addr.size()) begin
            errors++;
            $display("FAIL beat_count got %0d required %0d", got_addr.size(), e_addr.size());
        end
        cmp_n = (got_addr.size() < e_addr.size()) ? got_addr.size() : e_addr.size();
        for (int i = 0; i < int'(cmp_n); i++) begin
            checks++;
            if (got_addr[i] !== e_addr[i] || got_bc[i] !== e_bc[i] || got_data[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL beat[%0d] addr=%h bc=%0d required addr=%h bc=%0d (data %s)",
                         i, got_addr[i], got_bc[i], e_addr[i], e_bc[i],
                         (got_data[i] === exp_words[i]) ? "ok" : "wrong");
            end
        end
        checks++;
        if (wr_offset !== AW'(off) || wrapped !== e_wrap || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL final_status offset=%h wrapped=%b busy=%b ready=%b required offset=%h wrapped=%b busy=0 ready=0",
                     wr_offset, wrapped, busy, in_ready, AW'(off), e_wrap);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        base_addr = '0; buf_words = '0; n_total = 0; wr_mode = 0; fast = 1'b0;
        reset_tb();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (avm_write !== 1'b0 || in_ready !== 1'b0 || avm_address !== '0 || avm_burstcount !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || wrapped !== 1'b0 || wr_offset !== '0) begin
            errors++;
            $display("FAIL reset_state write=%b ready=%b addr=%h bc=%0d busy=%b done=%b wrapped=%b off=%h required all 0",
                     avm_write, in_ready, avm_address, avm_burstcount, busy, done, wrapped, wr_offset);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_sequential();
        run_capture(AW'('h100), 32, 32, 0, 1'b1, 1'b0);
    endtask

    task automatic test_waitrequest_stall();
        run_capture(AW'($urandom), 32, 16, 2, 1'b1, 1'b0);
        checks++;
        if (stall_seen != 5) begin
            errors++; $display("FAIL stall_cycles got %0d required 5", stall_seen);
        end
    endtask

    task automatic test_ring();
        run_capture(AW'('h4000), 16, 40, 1, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        run_capture(AW'('h800), 32, 3, 0, 1'b1, 1'b0);
        run_capture(AW'('h900), 32, 0, 0, 1'b1, 1'b0);
        run_capture(AW'('h1000), 32, 13, 1, 1'b0, 1'b0);
    endtask

    task automatic test_addr_wrap();
        run_capture(AW'((1 << AW) - 12), 24, 24, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        reset_tb();
        n_total = 16; wr_mode = 0; fast = 1'b1;
        while (pushed < n_total) push_word();
        drive_fifo();
        base_addr = AW'('h200); buf_words = AW'(32); start = 1'b1;
        cycle();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            cycle();
            if (got_addr.size() == 3) seen = 1'b1;
        end
        checks++;
        if (!seen || avm_write !== 1'b1) begin
            errors++; $display("FAIL beat4_present seen=%b write=%b required 1 1", seen, avm_write);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (avm_write !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            avm_address !== '0 || avm_burstcount !== '0 || wr_offset !== '0) begin
            errors++;
            $display("FAIL async_reset write=%b ready=%b busy=%b done=%b addr=%h bc=%0d off=%h required all 0",
                     avm_write, in_ready, busy, done, avm_address, avm_burstcount, wr_offset);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_capture(AW'('h300), 16, 16, 1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_capture(AW'('h2000), 24, 24, 1, 1'b0, 1'b1);
        run_capture(AW'('h3000), 16, 16, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int unsigned bw;
            bw = BL * $urandom_range(1, 6);
            run_capture(AW'($urandom), bw, $urandom_range(0, bw + BL + 3), 1,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_waitrequest_stall();
        test_ring();
        test_flush();
        test_addr_wrap();
        test_reset_mid_burst();
        test_start_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
